bus_timer_responder: RTL and testbench

- Memory-mapped 64-bit timer/compare peripheral; a responder on the core's data bus (data_req/we/be/addr/wdata/rdata), alongside the data RAM and the LED register.
- Lets software build delays and periodic LED blinks from a real time base instead of busy loops.
- Drives a sticky interrupt/status line that the top can route to an LED or to a core interrupt input.

---
 rtl/timer_pkg.sv | 29 ++
 rtl/timer_prescaler.sv | 31 +++
 rtl/bus_timer_responder.sv | 167 ++++++++++++++++
 tb/tb_bus_timer_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the bus timer responder: register offsets (word index
// taken from address bits [4:2]), CTRL/STATUS bit positions, and a
// byte-enable merge helper.
package timer_pkg;

  localparam logic [2:0] MTIME_LO_OFF = 3'd0;
  localparam logic [2:0] MTIME_HI_OFF = 3'd1;
  localparam logic [2:0] CMP_LO_OFF   = 3'd2;
  localparam logic [2:0] CMP_HI_OFF   = 3'd3;
  localparam logic [2:0] CTRL_OFF     = 3'd4;
  localparam logic [2:0] STATUS_OFF   = 3'd5;

  localparam int CTRL_EN_BIT        = 0;
  localparam int CTRL_RELOAD_BIT    = 1;
  localparam int CTRL_DIV_LSB       = 16;
  localparam int STATUS_PENDING_BIT = 0;

  // Replace only the bytes whose enable is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the bus timer: emits one tick every DIV+1 enabled cycles.
// clr restarts the count (used when CTRL is rewritten).
module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  sys_reset_n,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_div,
  input  logic                  i_clr,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_count;

  assign o_tick = i_en && (r_count == i_div);

  // Count register: wraps on tick, holds while disabled, cleared by clr.
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (o_tick) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/bus_timer_responder.sv
// Memory-mapped 64-bit timer/compare responder on the core data bus.
// Optional macro TIMER_AUTORELOAD_EN adds CTRL[1] RELOAD: MTIME returns to 0
// when a tick would reach CMP, giving a periodic PENDING.
module bus_timer_responder
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          PRESCALE_W = 16,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        sys_reset_n,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        timer_irq
);

  logic [63:0]           r_mtime;
  logic [63:0]           r_cmp;
  logic                  r_en;
  logic [PRESCALE_W-1:0] r_div;
  logic                  r_pending;
  logic                  r_valid;
  logic [31:0]           r_rdata;

  logic                  w_sel;
  logic [2:0]            w_off;
  logic                  w_wr;
  logic                  w_tick;
  logic                  w_reload;
  logic                  w_reload_hit;
  logic                  w_match;
  logic                  w_clr_pending;
  logic [31:0]           w_ctrl_word;
  logic [31:0]           w_ctrl_merge;
  logic [31:0]           w_rd_word;
  logic [63:0]           w_mtime_inc;
  logic [63:0]           w_mtime_tick;
  logic [63:0]           w_mtime_nxt;
  logic                  w_unused;

  assign w_sel   = data_req && (data_addr[31:12] == BASE_ADDR[31:12]);
  assign w_off   = data_addr[4:2];
  assign w_wr    = w_sel && data_we;
  assign w_match = (r_mtime >= r_cmp);
  assign w_clr_pending = w_wr && (w_off == STATUS_OFF) && data_be[0]
                         && data_wdata[STATUS_PENDING_BIT];
  assign w_ctrl_merge = be_merge(w_ctrl_word, data_wdata, data_be);
  assign w_mtime_inc  = r_mtime + 64'd1;
  assign w_unused = &{1'b0, data_addr[11:5], data_addr[1:0], w_ctrl_merge};

  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk         (clk),
    .sys_reset_n (sys_reset_n),
    .i_en        (r_en),
    .i_div       (r_div),
    .i_clr       (w_wr && (w_off == CTRL_OFF)),
    .o_tick      (w_tick)
  );

`ifdef TIMER_AUTORELOAD_EN
  logic r_reload;

  assign w_reload     = r_reload;
  assign w_reload_hit = w_tick && r_reload && (w_mtime_inc >= r_cmp);

  // RELOAD bit, written alongside the rest of CTRL.
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_reload <= 1'b0;
    end else if (w_wr && (w_off == CTRL_OFF)) begin
      r_reload <= w_ctrl_merge[CTRL_RELOAD_BIT];
    end
  end
`else
  assign w_reload     = 1'b0;
  assign w_reload_hit = 1'b0;
`endif

  // CTRL as seen on the bus; also the base for byte-merged writes.
  always_comb begin
    w_ctrl_word = '0;
    w_ctrl_word[CTRL_EN_BIT]                   = r_en;
    w_ctrl_word[CTRL_RELOAD_BIT]               = w_reload;
    w_ctrl_word[CTRL_DIV_LSB +: PRESCALE_W]    = r_div;
  end

  // Read mux over the register map; unmapped offsets read 0.
  always_comb begin
    w_rd_word = '0;
    case (w_off)
      MTIME_LO_OFF: w_rd_word = r_mtime[31:0];
      MTIME_HI_OFF: w_rd_word = r_mtime[63:32];
      CMP_LO_OFF:   w_rd_word = r_cmp[31:0];
      CMP_HI_OFF:   w_rd_word = r_cmp[63:32];
      CTRL_OFF:     w_rd_word = w_ctrl_word;
      STATUS_OFF:   w_rd_word[STATUS_PENDING_BIT] = r_pending;
      default:      w_rd_word = '0;
    endcase
  end

  // Next MTIME: tick/reload first, then a bus write overrides only its half,
  // so the untouched half still sees the carry.
  always_comb begin
    w_mtime_tick = w_tick ? w_mtime_inc : r_mtime;
    if (w_reload_hit) begin
      w_mtime_tick = '0;
    end
    w_mtime_nxt = w_mtime_tick;
    if (w_wr && (w_off == MTIME_LO_OFF)) begin
      w_mtime_nxt[31:0] = be_merge(r_mtime[31:0], data_wdata, data_be);
    end
    if (w_wr && (w_off == MTIME_HI_OFF)) begin
      w_mtime_nxt[63:32] = be_merge(r_mtime[63:32], data_wdata, data_be);
    end
  end

  // Timer, compare, control and pending state.
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_mtime   <= '0;
      r_cmp     <= CMP_RESET;
      r_en      <= 1'b0;
      r_div     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_mtime <= w_mtime_nxt;
      if (w_wr && (w_off == CMP_LO_OFF)) begin
        r_cmp[31:0] <= be_merge(r_cmp[31:0], data_wdata, data_be);
      end
      if (w_wr && (w_off == CMP_HI_OFF)) begin
        r_cmp[63:32] <= be_merge(r_cmp[63:32], data_wdata, data_be);
      end
      if (w_wr && (w_off == CTRL_OFF)) begin
        r_en  <= w_ctrl_merge[CTRL_EN_BIT];
        r_div <= w_ctrl_merge[CTRL_DIV_LSB +: PRESCALE_W];
      end
      // Set has priority over a same-cycle software clear.
      if (w_match || w_reload_hit) begin
        r_pending <= 1'b1;
      end else if (w_clr_pending) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Bus response: one registered valid/rdata per selected request.
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_valid <= w_sel;
      r_rdata <= (w_sel && !data_we) ? w_rd_word : '0;
    end
  end

  assign data_valid = r_valid;
  assign data_rdata = r_rdata;
  assign timer_irq  = r_pending;

endmodule

// File: tb/tb_bus_timer_responder.sv
// Directed bench for bus_timer_responder: register reset values, prescaled
// counting, enable hold, 64-bit carry, compare/pending set-wins-clear,
// byte enables, handshake timing and asynchronous reset during an access.
module tb_bus_timer_responder;

  logic        clk;
  logic        sys_reset_n;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        timer_irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  localparam logic [31:0] B = 32'h3000_0000;

  bus_timer_responder dut (
    .clk         (clk),
    .sys_reset_n (sys_reset_n),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_be     (data_be),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_valid  (data_valid),
    .timer_irq   (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One access: drive on a falling edge, sample the response one cycle later.
  task automatic bus_xfer(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    @(negedge clk);
    data_req   = 1'b1;
    data_we    = we;
    data_be    = be;
    data_addr  = addr;
    data_wdata = wdata;
    @(negedge clk);
    data_req   = 1'b0;
    data_we    = 1'b0;
    check("valid", {63'd0, data_valid}, 64'd1);
    rdata = data_rdata;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] dummy;
    bus_xfer(addr, 1'b1, be, wdata, dummy);
    check("wr_rdata_zero", {32'd0, dummy}, 64'd0);
  endtask

  task automatic rdw(input logic [31:0] addr, output logic [31:0] rdata);
    bus_xfer(addr, 1'b0, 4'h0, 32'h0, rdata);
  endtask

  initial begin
    sys_reset_n = 1'b0;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = '0; data_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", {63'd0, data_valid}, 64'd0);
    check("rst_rdata", {32'd0, data_rdata}, 64'd0);
    check("rst_irq", {63'd0, timer_irq}, 64'd0);
    sys_reset_n = 1'b1;

    // Reset values
    rdw(B + 32'h10, rd); check("rst_ctrl", {32'd0, rd}, 64'h0);
    rdw(B + 32'h08, rd); check("rst_cmp_lo", {32'd0, rd}, 64'hFFFF_FFFF);
    rdw(B + 32'h0C, rd); check("rst_cmp_hi", {32'd0, rd}, 64'hFFFF_FFFF);
    check("rst_irq2", {63'd0, timer_irq}, 64'd0);
    @(negedge clk);
    check("idle_valid", {63'd0, data_valid}, 64'd0);

    // Prescaled counting: DIV=3 ticks at write edge +4,+8,...; read sampled 41 cycles later.
    wr(B + 32'h10, 32'h0003_0001, 4'hF);
    repeat (40) @(negedge clk);
    rdw(B + 32'h00, rd); check("div3_mtime", {32'd0, rd}, 64'd10);
    // Disable lands on a tick edge (+44), so MTIME holds at 11.
    wr(B + 32'h10, 32'h0003_0000, 4'hF);
    rdw(B + 32'h00, rd); check("hold_a", {32'd0, rd}, 64'd11);
    repeat (20) @(negedge clk);
    rdw(B + 32'h00, rd); check("hold_b", {32'd0, rd}, 64'd11);

    // Carry LO->HI with DIV=0: ticks from enable edge+1.
    wr(B + 32'h10, 32'h0, 4'hF);
    wr(B + 32'h00, 32'hFFFF_FFFE, 4'hF);
    wr(B + 32'h04, 32'h0, 4'hF);
    wr(B + 32'h10, 32'h1, 4'hF);
    repeat (4) @(negedge clk);
    rdw(B + 32'h00, rd); check("carry_lo", {32'd0, rd}, 64'd3);
    rdw(B + 32'h04, rd); check("carry_hi", {32'd0, rd}, 64'd1);

    // Compare and sticky pending.
    wr(B + 32'h10, 32'h0, 4'hF);
    wr(B + 32'h04, 32'h0, 4'hF);
    wr(B + 32'h00, 32'h0, 4'hF);
    wr(B + 32'h08, 32'h20, 4'hF);
    wr(B + 32'h0C, 32'h0, 4'hF);
    wr(B + 32'h14, 32'h1, 4'hF);
    check("irq_before", {63'd0, timer_irq}, 64'd0);
    wr(B + 32'h10, 32'h1, 4'hF);
    repeat (30) @(negedge clk);
    check("irq_not_yet", {63'd0, timer_irq}, 64'd0);
    repeat (4) @(negedge clk);
    check("irq_set", {63'd0, timer_irq}, 64'd1);
    rdw(B + 32'h14, rd); check("status_rd", {32'd0, rd}, 64'd1);
    wr(B + 32'h14, 32'h1, 4'hF);
    check("set_wins", {63'd0, timer_irq}, 64'd1);
    wr(B + 32'h0C, 32'hFFFF_FFFF, 4'hF);
    check("irq_sticky", {63'd0, timer_irq}, 64'd1);
    wr(B + 32'h14, 32'h1, 4'hF);
    check("irq_cleared", {63'd0, timer_irq}, 64'd0);

    // Byte enables and unmapped offset.
    wr(B + 32'h08, 32'hFFFF_FFFF, 4'hF);
    wr(B + 32'h08, 32'hAABB_CCDD, 4'b0101);
    rdw(B + 32'h08, rd); check("be_merge", {32'd0, rd}, 64'hFFBB_FFDD);
    rdw(B + 32'h18, rd); check("unmapped", {32'd0, rd}, 64'h0);
    rdw(B + 32'h0B, rd); check("addr_lsb_ignored", {32'd0, rd}, 64'hFFBB_FFDD);

    // Back-to-back requests and an out-of-region request.
    @(negedge clk);
    data_req = 1'b1; data_we = 1'b0; data_addr = B + 32'h08;
    @(negedge clk);
    check("b2b_valid0", {63'd0, data_valid}, 64'd1);
    check("b2b_rdata0", {32'd0, data_rdata}, 64'hFFBB_FFDD);
    data_addr = B + 32'h0C;
    @(negedge clk);
    check("b2b_valid1", {63'd0, data_valid}, 64'd1);
    check("b2b_rdata1", {32'd0, data_rdata}, 64'hFFFF_FFFF);
    data_addr = 32'h4000_0008;
    @(negedge clk);
    data_req = 1'b0;
    check("other_region", {63'd0, data_valid}, 64'd0);
    check("other_rdata", {32'd0, data_rdata}, 64'd0);

`ifdef TIMER_AUTORELOAD_EN
    wr(B + 32'h10, 32'h0, 4'hF);
    wr(B + 32'h00, 32'h0, 4'hF);
    wr(B + 32'h04, 32'h0, 4'hF);
    wr(B + 32'h08, 32'h5, 4'hF);
    wr(B + 32'h0C, 32'h0, 4'hF);
    wr(B + 32'h14, 32'h1, 4'hF);
    check("ar_irq_clear", {63'd0, timer_irq}, 64'd0);
    wr(B + 32'h10, 32'h3, 4'hF);
    rdw(B + 32'h10, rd); check("ar_ctrl", {32'd0, rd}, 64'h3);
    repeat (6) @(negedge clk);
    check("ar_irq_set", {63'd0, timer_irq}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      rdw(B + 32'h00, rd); check("ar_lo_below_cmp", {63'd0, rd < 32'd5}, 64'd1);
      rdw(B + 32'h04, rd); check("ar_hi_zero", {32'd0, rd}, 64'd0);
    end
`else
    wr(B + 32'h10, 32'h3, 4'hF);
    rdw(B + 32'h10, rd); check("ctrl_no_reload", {32'd0, rd}, 64'h1);
`endif

    // Reset during an access drops the pending response at once.
    wr(B + 32'h14, 32'h0, 4'hF);
    @(negedge clk);
    data_req = 1'b1; data_we = 1'b0; data_addr = B + 32'h08;
    @(negedge clk);
    data_req = 1'b0;
    check("pre_rst_valid", {63'd0, data_valid}, 64'd1);
    sys_reset_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, data_valid}, 64'd0);
    check("async_rst_rdata", {32'd0, data_rdata}, 64'd0);
    check("async_rst_irq", {63'd0, timer_irq}, 64'd0);
    @(negedge clk);
    sys_reset_n = 1'b1;
    rdw(B + 32'h08, rd); check("post_rst_cmp", {32'd0, rd}, 64'hFFFF_FFFF);
    rdw(B + 32'h00, rd); check("post_rst_mtime", {32'd0, rd}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
